midi_cc_parser: RTL and testbench
=================================

MIDI_CC_PARSER -- requirements
Module: midi_cc_parser

Interface
REQ-001 Parameter CHANNEL, default 4'd0, MIDI channel (0-15) whose Control Change messages are accepted.
REQ-002 Parameter OMNI, default 1'b0, when 1 accepts Control Change on all channels and ignores CHANNEL.
REQ-003 clk500kHz  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 midi_rdy  input  1  byte-ready flag from the serial-to-parallel stage; level or pulse.
REQ-006 midi_byte  input  8  received MIDI byte; sampled in the cycle a midi_rdy rising edge is detected.
REQ-007 value  output  7  data byte 2 (controller value) of the last accepted Control Change.
REQ-008 ctrlnum  output  16  {status byte, 1'b0, 7-bit controller number} of the last accepted Control Change.
REQ-009 cc_valid  output  1  one-cycle strobe when value/ctrlnum update.
REQ-010 sync_err  output  1  one-cycle strobe on a data byte arriving with no running status.

Function
REQ-011 The block SHALL register midi_rdy and accept a byte only on a 0->1 transition, so at most one byte is accepted per high period.
REQ-012 Byte classes: 8'hF8-8'hFF real-time; 8'hF0-8'hF7 system common/SysEx; 8'h80-8'hEF channel voice status; 8'h00-8'h7F data.
REQ-013 Real-time bytes SHALL be discarded with no change to state, running status or outputs, in every state.
REQ-014 States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX, SKIP1, SKIP2.
REQ-015 Accepted CC status (upper nibble 4'hB, channel matches or OMNI=1): store as running status, go to WAIT_D1.
REQ-016 Other channel voice status: store as running status; upper nibble 4'hC or 4'hD -> SKIP1; otherwise -> SKIP2.
REQ-017 Non-matching CC channel SHALL be treated as a two-data-byte message -> SKIP2.
REQ-018 8'hF0 -> SYSEX, clear running status; 8'hF1-8'hF7 -> IDLE, clear running status.
REQ-019 SYSEX: data bytes discarded; 8'hF7 -> IDLE; any other status byte processed per REQ-015..018.
REQ-020 WAIT_D1 + data byte: latch controller number, -> WAIT_D2.
REQ-021 WAIT_D2 + data byte: latch value, update ctrlnum and value, pulse cc_valid in the next cycle, -> WAIT_D1 (running status).
REQ-022 SKIP2 + data byte -> SKIP1; SKIP1 + data byte -> WAIT_D1 if running status is accepted CC, else SKIP2 or SKIP1 per running-status type (running status honoured for skipped messages).
REQ-023 A status byte in WAIT_D1, WAIT_D2, SKIP1 or SKIP2 SHALL abort the partial message (no cc_valid) and be processed per REQ-015..018.
REQ-024 IDLE + data byte: discard, pulse sync_err for one cycle, remain IDLE.
REQ-025 Latency: cc_valid asserts exactly one clk500kHz cycle after the cycle the second data byte is accepted; value/ctrlnum change in the same cycle cc_valid is high and hold until the next accepted CC.
REQ-026 cc_valid and sync_err SHALL never be high for more than one consecutive cycle.
REQ-027 Controller number 7'h7F and value 7'h7F SHALL pass unmodified; ctrlnum[7] is always 0.

Reset
REQ-028 reset SHALL take priority over a coincident byte; that byte is discarded.
REQ-029 On reset: state IDLE, running status cleared, edge-detect register 0, value 7'd0, ctrlnum 16'd0, cc_valid 0, sync_err 0.
REQ-030 Reset asserted mid-message SHALL discard the partial message with no cc_valid.

Verification
REQ-031 CHANNEL=0: bytes B0,07,64 -> one cc_valid; ctrlnum=16'hB007, value=7'h64.
REQ-032 After REQ-031, bytes 0A,7F (running status) -> cc_valid; ctrlnum=16'hB00A, value=7'h7F.
REQ-033 B0,F8,07,FE,40 -> one cc_valid, ctrlnum=16'hB007, value=7'h40; real-time bytes ignored.
REQ-034 CHANNEL=0, OMNI=0: B3,07,10 then C0,05 then 90,3C,40 -> no cc_valid; value/ctrlnum unchanged.
REQ-035 F0,01,02,F7,05 after reset -> no cc_valid, one sync_err on byte 05; B0,07 then reset then 20 -> no cc_valid, outputs zero.
REQ-036 midi_rdy held high 10 cycles with B0, then 07, then 55 -> exactly one cc_valid, value=7'h55.

Source files
------------

// File: rtl/midi_cc_parser.sv
// MIDI Control Change parser.
// Accepts one byte per rising edge of midi_rdy, tracks running status, filters
// Control Change messages by channel (or all channels with OMNI) and presents
// the last accepted controller number and value.
// Ports:
//   clk500kHz  - sole clock
//   reset      - synchronous active-high reset
//   midi_rdy   - byte-ready flag (level or pulse)
//   midi_byte  - received MIDI byte
//   value      - controller value of last accepted CC
//   ctrlnum    - {status, 1'b0, controller number} of last accepted CC
//   cc_valid   - one-cycle strobe when value/ctrlnum update
//   sync_err   - one-cycle strobe on a data byte with no running status
module midi_cc_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic        clk500kHz,
    input  logic        reset,
    input  logic        midi_rdy,
    input  logic [7:0]  midi_byte,
    output logic [6:0]  value,
    output logic [15:0] ctrlnum,
    output logic        cc_valid,
    output logic        sync_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_D1 = 3'd1,
        WAIT_D2 = 3'd2,
        SYSEX   = 3'd3,
        SKIP1   = 3'd4,
        SKIP2   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rdy_q;
    logic [7:0]  run_status;
    logic [7:0]  run_status_nxt;
    logic [6:0]  cnum;
    logic [6:0]  cnum_nxt;
    logic        take_c;
    logic        cc_fire_c;
    logic        err_fire_c;

    // Accept a byte only on the 0->1 transition of midi_rdy
    assign take_c = midi_rdy & ~rdy_q;

    // Where a channel voice status (new or running) sends the parser next
    function automatic state_t voice_target(input logic [7:0] s);
        if (s[7:4] == 4'hB && (OMNI || s[3:0] == CHANNEL)) begin
            return WAIT_D1;
        end else if (s[7:4] == 4'hC || s[7:4] == 4'hD) begin
            return SKIP1;
        end else begin
            return SKIP2;
        end
    endfunction

    // Next-state and running-status logic
    always_comb begin
        state_nxt      = state;
        run_status_nxt = run_status;
        cnum_nxt       = cnum;
        cc_fire_c      = 1'b0;
        err_fire_c     = 1'b0;
        if (take_c) begin
            if (!midi_byte[7]) begin
                case (state)
                    IDLE:    err_fire_c = 1'b1;
                    WAIT_D1: begin
                        cnum_nxt  = midi_byte[6:0];
                        state_nxt = WAIT_D2;
                    end
                    WAIT_D2: begin
                        cc_fire_c = 1'b1;
                        state_nxt = WAIT_D1;
                    end
                    SYSEX:   state_nxt = SYSEX;
                    SKIP2:   state_nxt = SKIP1;
                    SKIP1:   state_nxt = voice_target(run_status);
                    default: state_nxt = IDLE;
                endcase
            end else if (midi_byte >= 8'hF8) begin
                // Real-time bytes are transparent to the parser
                state_nxt = state;
            end else if (midi_byte == 8'hF0) begin
                state_nxt      = SYSEX;
                run_status_nxt = 8'h00;
            end else if (midi_byte >= 8'hF1) begin
                state_nxt      = IDLE;
                run_status_nxt = 8'h00;
            end else begin
                // Any channel voice status aborts a partial message
                run_status_nxt = midi_byte;
                state_nxt      = voice_target(midi_byte);
            end
        end
    end

    // State register
    always_ff @(posedge clk500kHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk500kHz) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            run_status <= 8'h00;
            cnum       <= 7'd0;
            value      <= 7'd0;
            ctrlnum    <= 16'd0;
            cc_valid   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            rdy_q      <= midi_rdy;
            run_status <= run_status_nxt;
            cnum       <= cnum_nxt;
            cc_valid   <= cc_fire_c;
            sync_err   <= err_fire_c;
            if (cc_fire_c) begin
                value   <= midi_byte[6:0];
                ctrlnum <= {run_status, 1'b0, cnum};
            end
        end
    end

endmodule

// File: tb/tb_midi_cc_parser.sv
// Testbench for midi_cc_parser: a default instance (channel 0) and an OMNI
// instance (CHANNEL=5, OMNI=1) share the same byte stream; expected CC events
// are queued per instance and matched against cc_valid as it appears.
`timescale 1ns/1ps
module tb_midi_cc_parser;

    logic        clk500kHz = 1'b0;
    logic        reset;
    logic        midi_rdy;
    logic [7:0]  midi_byte;
    logic [6:0]  m_value,   o_value;
    logic [15:0] m_ctrlnum, o_ctrlnum;
    logic        m_cc, o_cc, m_err, o_err;

    typedef struct {
        logic [15:0] ctrlnum;
        logic [6:0]  value;
        int          cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_omni[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_err = 0;
    int m_err_cnt = 0;
    int o_err_cnt = 0;
    logic m_cc_prev = 1'b0, o_cc_prev = 1'b0, m_err_prev = 1'b0, o_err_prev = 1'b0;

    midi_cc_parser dut_main (
        .clk500kHz (clk500kHz),
        .reset     (reset),
        .midi_rdy  (midi_rdy),
        .midi_byte (midi_byte),
        .value     (m_value),
        .ctrlnum   (m_ctrlnum),
        .cc_valid  (m_cc),
        .sync_err  (m_err)
    );

    midi_cc_parser #(.CHANNEL(4'd5), .OMNI(1'b1)) dut_omni (
        .clk500kHz (clk500kHz),
        .reset     (reset),
        .midi_rdy  (midi_rdy),
        .midi_byte (midi_byte),
        .value     (o_value),
        .ctrlnum   (o_ctrlnum),
        .cc_valid  (o_cc),
        .sync_err  (o_err)
    );

    always #1000 clk500kHz = ~clk500kHz;

    always @(posedge clk500kHz) cyc <= cyc + 1;

    // Scoreboard: every cc_valid pulse must match the head of its queue
    always @(negedge clk500kHz) begin
        exp_t e;
        if (m_cc === 1'b1) begin
            vectors++;
            if (q_main.size() == 0) begin
                miscompares++;
                $display("FAIL main_cc_unexpected: got ctrlnum=%h value=%h, required no cc_valid", m_ctrlnum, m_value);
            end else begin
                e = q_main.pop_front();
                if (m_ctrlnum !== e.ctrlnum || m_value !== e.value || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL main_cc: got %h/%h cyc %0d, required %h/%h cyc %0d",
                             m_ctrlnum, m_value, cyc, e.ctrlnum, e.value, e.cyc);
                end
            end
            if (m_cc_prev) begin
                miscompares++;
                $display("FAIL main_cc_width: got cc_valid high 2 cycles, required 1");
            end
        end
        if (o_cc === 1'b1) begin
            vectors++;
            if (q_omni.size() == 0) begin
                miscompares++;
                $display("FAIL omni_cc_unexpected: got ctrlnum=%h value=%h, required no cc_valid", o_ctrlnum, o_value);
            end else begin
                e = q_omni.pop_front();
                if (o_ctrlnum !== e.ctrlnum || o_value !== e.value || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL omni_cc: got %h/%h cyc %0d, required %h/%h cyc %0d",
                             o_ctrlnum, o_value, cyc, e.ctrlnum, e.value, e.cyc);
                end
            end
            if (o_cc_prev) begin
                miscompares++;
                $display("FAIL omni_cc_width: got cc_valid high 2 cycles, required 1");
            end
        end
        if (m_err === 1'b1) begin
            m_err_cnt++;
            vectors++;
            if (m_err_prev) begin
                miscompares++;
                $display("FAIL main_err_width: got sync_err high 2 cycles, required 1");
            end
        end
        if (o_err === 1'b1) begin
            o_err_cnt++;
            vectors++;
            if (o_err_prev) begin
                miscompares++;
                $display("FAIL omni_err_width: got sync_err high 2 cycles, required 1");
            end
        end
        m_cc_prev  = (m_cc === 1'b1);
        o_cc_prev  = (o_cc === 1'b1);
        m_err_prev = (m_err === 1'b1);
        o_err_prev = (o_err === 1'b1);
    end

    // Present one byte with a rising midi_rdy held for 'hold' cycles, then idle one cycle
    task automatic send(input logic [7:0] b, input int hold);
        midi_byte = b;
        midi_rdy  = 1'b1;
        repeat (hold) begin
            @(posedge clk500kHz);
            #1;
        end
        midi_rdy = 1'b0;
        @(posedge clk500kHz);
        #1;
    endtask

    // Queue an expected CC; must be called just before sending the second data byte
    task automatic expect_cc(input logic [15:0] cn, input logic [6:0] v, input bit to_main, input bit to_omni);
        exp_t e;
        e.ctrlnum = cn;
        e.value   = v;
        e.cyc     = cyc + 1;
        if (to_main) q_main.push_back(e);
        if (to_omni) q_omni.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk500kHz);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        midi_rdy  = 1'b0;
        midi_byte = 8'h00;
        repeat (2) begin
            @(posedge clk500kHz);
            #1;
        end
        reset = 1'b0;
        vectors++;
        if ({m_value, m_ctrlnum, m_cc, m_err} !== 25'd0) begin
            miscompares++;
            $display("FAIL main_reset: got %h/%h/%b/%b, required all zero", m_value, m_ctrlnum, m_cc, m_err);
        end
        vectors++;
        if ({o_value, o_ctrlnum, o_cc, o_err} !== 25'd0) begin
            miscompares++;
            $display("FAIL omni_reset: got %h/%h/%b/%b, required all zero", o_value, o_ctrlnum, o_cc, o_err);
        end
    endtask

    task automatic test_basic();
        send(8'hB0, 1);
        send(8'h07, 1);
        expect_cc(16'hB007, 7'h64, 1'b1, 1'b1);
        send(8'h64, 1);
    endtask

    task automatic test_running_status();
        send(8'h0A, 1);
        expect_cc(16'hB00A, 7'h7F, 1'b1, 1'b1);
        send(8'h7F, 1);
    endtask

    task automatic test_realtime();
        send(8'hB0, 1);
        send(8'hF8, 1);
        send(8'h07, 1);
        send(8'hFE, 1);
        expect_cc(16'hB007, 7'h40, 1'b1, 1'b1);
        send(8'h40, 1);
    endtask

    task automatic test_filter();
        logic [7:0] seq[11];
        seq = '{8'hC0, 8'h05, 8'h06, 8'h90, 8'h3C, 8'h40, 8'h3C, 8'h40, 8'hB3, 8'h08, 8'h11};
        send(8'hB3, 1);
        send(8'h07, 1);
        expect_cc(16'hB307, 7'h10, 1'b0, 1'b1);
        send(8'h10, 1);
        // Skipped messages with running status, then a foreign CC only OMNI takes
        for (int i = 0; i < 10; i++) send(seq[i], 1);
        expect_cc(16'hB308, 7'h11, 1'b0, 1'b1);
        send(seq[10], 1);
        vectors++;
        if (m_ctrlnum !== 16'hB007 || m_value !== 7'h40) begin
            miscompares++;
            $display("FAIL main_filter_hold: got %h/%h, required b007/40", m_ctrlnum, m_value);
        end
        vectors++;
        if (o_ctrlnum !== 16'hB308 || o_value !== 7'h11) begin
            miscompares++;
            $display("FAIL omni_filter: got %h/%h, required b308/11", o_ctrlnum, o_value);
        end
    endtask

    task automatic test_sysex();
        logic [7:0] seq[5];
        seq = '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h05};
        pulse_reset();
        for (int i = 0; i < 5; i++) send(seq[i], 1);
        exp_err++;
        send(8'hB0, 1);
        send(8'h7F, 1);
        expect_cc(16'hB07F, 7'h7F, 1'b1, 1'b1);
        send(8'h7F, 1);
        vectors++;
        if (m_err_cnt != exp_err || o_err_cnt != exp_err) begin
            miscompares++;
            $display("FAIL sysex_sync_err: got %0d/%0d, required %0d", m_err_cnt, o_err_cnt, exp_err);
        end
    endtask

    task automatic test_reset_mid_message();
        send(8'hB0, 1);
        send(8'h07, 1);
        pulse_reset();
        send(8'h20, 1);
        exp_err++;
        vectors++;
        if ({m_value, m_ctrlnum, o_value, o_ctrlnum} !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h/%h %h/%h, required zero", m_value, m_ctrlnum, o_value, o_ctrlnum);
        end
        vectors++;
        if (m_err_cnt != exp_err || o_err_cnt != exp_err) begin
            miscompares++;
            $display("FAIL reset_mid_sync_err: got %0d/%0d, required %0d", m_err_cnt, o_err_cnt, exp_err);
        end
    endtask

    task automatic test_reset_coincident();
        // A data byte arriving with reset in IDLE must not raise sync_err
        reset     = 1'b1;
        midi_rdy  = 1'b1;
        midi_byte = 8'h05;
        @(posedge clk500kHz);
        #1;
        reset    = 1'b0;
        midi_rdy = 1'b0;
        repeat (2) begin
            @(posedge clk500kHz);
            #1;
        end
        vectors++;
        if (m_err_cnt != exp_err || o_err_cnt != exp_err) begin
            miscompares++;
            $display("FAIL reset_coincident: got %0d/%0d sync_err, required %0d", m_err_cnt, o_err_cnt, exp_err);
        end
    endtask

    task automatic test_held_rdy();
        send(8'hB0, 10);
        send(8'h07, 1);
        expect_cc(16'hB007, 7'h55, 1'b1, 1'b1);
        send(8'h55, 3);
        vectors++;
        if (m_value !== 7'h55 || o_value !== 7'h55) begin
            miscompares++;
            $display("FAIL held_rdy_value: got %h/%h, required 55", m_value, o_value);
        end
    endtask

    task automatic test_back_to_back();
        send(8'hB0, 1);
        send(8'h07, 1);
        send(8'hB0, 1);
        send(8'h01, 1);
        expect_cc(16'hB001, 7'h02, 1'b1, 1'b1);
        send(8'h02, 1);
        send(8'h11, 1);
        expect_cc(16'hB011, 7'h22, 1'b1, 1'b1);
        send(8'h22, 1);
        send(8'h03, 1);
        send(8'hF1, 1);
        send(8'h05, 1);
        exp_err++;
        vectors++;
        if (m_err_cnt != exp_err || o_err_cnt != exp_err) begin
            miscompares++;
            $display("FAIL back_to_back_sync_err: got %0d/%0d, required %0d", m_err_cnt, o_err_cnt, exp_err);
        end
        vectors++;
        if (m_ctrlnum !== 16'hB011 || m_value !== 7'h22) begin
            miscompares++;
            $display("FAIL back_to_back_hold: got %h/%h, required b011/22", m_ctrlnum, m_value);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_running_status();
        test_realtime();
        test_filter();
        test_sysex();
        test_reset_mid_message();
        test_reset_coincident();
        test_held_rdy();
        test_back_to_back();
        repeat (3) begin
            @(posedge clk500kHz);
            #1;
        end
        vectors++;
        if (q_main.size() != 0 || q_omni.size() != 0) begin
            miscompares++;
            $display("FAIL cc_missing: got %0d/%0d pending, required 0", q_main.size(), q_omni.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
